// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC register, word-addressed ROM interface and a
// small prefetch queue presenting {pc, instr} pairs to decode over valid/ready.
module instr_fetch_unit #(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic              fetch_fault
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic             fault_q, fault_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      qpc_q[DEPTH];
  logic [31:0]      qpc_d[DEPTH];
  logic [31:0]      qinstr_q[DEPTH];
  logic [31:0]      qinstr_d[DEPTH];

  logic in_range;
  logic pop;
  logic push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign rom_addr    = pc_q[ADDR_W+1:2];
  assign in_range    = (pc_q >> (ADDR_W + 2)) == 32'd0;
  assign out_valid   = (count_q != '0);
  assign out_instr   = out_valid ? qinstr_q[rd_ptr_q] : 32'd0;
  assign out_pc      = out_valid ? qpc_q[rd_ptr_q] : 32'd0;
  assign fetch_fault = fault_q;

  // A redirect swallows any pop offered in the same cycle.
  assign pop  = out_valid && out_ready && !redirect_valid;
  assign push = !fault_q && !redirect_valid && in_range && ((count_q < DEPTH_C) || pop);

  always_comb begin
    pc_d     = pc_q;
    fault_d  = fault_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    qpc_d    = qpc_q;
    qinstr_d = qinstr_q;
    if (redirect_valid) begin
      pc_d     = {redirect_addr[31:2], 2'b00};
      fault_d  = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (!fault_q && !in_range) fault_d = 1'b1;
      if (push) begin
        qpc_d[wr_ptr_q]    = pc_q;
        qinstr_d[wr_ptr_q] = rom_instr;
        wr_ptr_d           = ptr_inc(wr_ptr_q);
        pc_d               = pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      fault_q  <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        qpc_q[i]    <= 32'd0;
        qinstr_q[i] <= 32'd0;
      end
    end else begin
      pc_q     <= pc_d;
      fault_q  <= fault_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      qpc_q    <= qpc_d;
      qinstr_q <= qinstr_d;
    end
  end

endmodule
